// File: rtl/tl_pkg.sv
// Shared definitions for the traffic phase controller.
//   phase_e   : phase encoding, 0..5; encodings 6 and 7 are illegal
//   LAMP_*    : one-hot lamp words, bit order {red, yellow, green}
//   main_lamp : lamp word for the main road in a given phase
//   side_lamp : lamp word for the side road in a given phase
package tl_pkg;

    typedef enum logic [2:0] {
        RED_M  = 3'd0,
        MAIN_G = 3'd1,
        MAIN_Y = 3'd2,
        RED_S  = 3'd3,
        SIDE_G = 3'd4,
        SIDE_Y = 3'd5
    } phase_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    function automatic logic [2:0] main_lamp(input phase_e p);
        case (p)
            MAIN_G:  main_lamp = LAMP_GRN;
            MAIN_Y:  main_lamp = LAMP_YEL;
            default: main_lamp = LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(input phase_e p);
        case (p)
            SIDE_G:  side_lamp = LAMP_GRN;
            SIDE_Y:  side_lamp = LAMP_YEL;
            default: side_lamp = LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Elapsed-seconds counter for the current phase.
//   clk    : system clock
//   reset  : asynchronous active-high reset, clears elapsed
//   clear  : phase change on this edge; elapsed restarts at 0
//   tick   : raw one-cycle seconds tick
//   hold   : suppress this tick (timer is being restarted)
//   dur    : phase duration in seconds; 0 behaves as 1
//   expire : this cycle carries the counted tick that ends the phase
// The counter saturates at dur-1 so a blocked exit keeps expiring on every
// later counted tick without wrapping.
module phase_counter
    import tl_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic             hold,
    input  logic [CNT_W-1:0] dur,
    output logic             expire
);

    logic [CNT_W-1:0] elapsed_q;
    logic [CNT_W-1:0] elapsed_d;
    logic [CNT_W-1:0] last;
    logic             counted;

    always_comb begin
        last      = (dur == '0) ? '0 : dur - CNT_W'(1);
        counted   = tick & ~hold;
        expire    = counted & (elapsed_q >= last);
        elapsed_d = elapsed_q;
        if (clear) begin
            elapsed_d = '0;
        end else if (counted && (elapsed_q < last)) begin
            elapsed_d = elapsed_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elapsed_q <= '0;
        end else begin
            elapsed_q <= elapsed_d;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer.
//   clk          : system clock
//   reset        : asynchronous active-high reset
//   sec_tick     : one-cycle pulse per second from the seconds timer
//   side_req     : side-road vehicle sensor (level)
//   emg_req      : emergency request (level)
//   rst_count    : one-cycle restart pulse to the seconds timer after each phase change
//   main_light   : main-road lamps {red, yellow, green}
//   side_light   : side-road lamps {red, yellow, green}
//   phase        : current phase encoding
//   side_pending : latched side request
// Build option: define SIDE_SENSOR_EN to hold main green until a side
// request has been latched; otherwise the cycle is fixed-time.
module traffic_phase_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned T_MAIN_GREEN = 20,
    parameter int unsigned T_SIDE_GREEN = 10,
    parameter int unsigned T_YELLOW     = 3,
    parameter int unsigned T_ALL_RED    = 1,
    parameter int unsigned CNT_W        = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       side_req,
    input  logic       emg_req,
    output logic       rst_count,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] phase,
    output logic       side_pending
);

    localparam logic [CNT_W-1:0] DurMainG = CNT_W'(T_MAIN_GREEN);
    localparam logic [CNT_W-1:0] DurSideG = CNT_W'(T_SIDE_GREEN);
    localparam logic [CNT_W-1:0] DurYel   = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] DurRed   = CNT_W'(T_ALL_RED);

    phase_e           phase_q;
    phase_e           phase_d;
    logic             rst_count_q;
    logic [2:0]       main_light_q;
    logic [2:0]       side_light_q;
    logic             phase_chg;
    logic [2:0]       main_light_d;
    logic [2:0]       side_light_d;
    logic [CNT_W-1:0] dur;
    logic             expire;
    logic             side_go;

    always_comb begin
        case (phase_q)
            MAIN_G:         dur = DurMainG;
            SIDE_G:         dur = DurSideG;
            MAIN_Y, SIDE_Y: dur = DurYel;
            default:        dur = DurRed;
        endcase
    end

    // A tick seen while rst_count is high belongs to the restarting timer.
    phase_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (phase_chg),
        .tick   (sec_tick),
        .hold   (rst_count_q),
        .dur    (dur),
        .expire (expire)
    );

`ifdef SIDE_SENSOR_EN
    logic side_pending_q;
    logic side_pending_d;

    always_comb begin
        side_pending_d = side_pending_q | side_req;
        if (phase_d == SIDE_G && phase_q != SIDE_G) begin
            side_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            side_pending_q <= 1'b0;
        end else begin
            side_pending_q <= side_pending_d;
        end
    end

    assign side_go      = side_pending_q;
    assign side_pending = side_pending_q;
`else
    logic unused_side_req;
    assign unused_side_req = side_req;
    assign side_go         = 1'b1;
    assign side_pending    = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= RED_M;
            rst_count_q  <= 1'b1;
            main_light_q <= LAMP_RED;
            side_light_q <= LAMP_RED;
        end else begin
            phase_q      <= phase_d;
            rst_count_q  <= phase_chg;
            main_light_q <= main_light_d;
            side_light_q <= side_light_d;
        end
    end

    // Next state. Emergency cuts greens short and freezes the all-red phases;
    // yellows always run to completion.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            RED_M:   if (expire && !emg_req) phase_d = MAIN_G;
            MAIN_G:  if (emg_req || (expire && side_go)) phase_d = MAIN_Y;
            MAIN_Y:  if (expire) phase_d = RED_S;
            RED_S:   if (expire && !emg_req) phase_d = SIDE_G;
            SIDE_G:  if (emg_req || expire) phase_d = SIDE_Y;
            SIDE_Y:  if (expire) phase_d = RED_M;
            default: phase_d = RED_M;
        endcase
    end

    // Lamps are decoded from the next state so they change on the same edge
    // as the phase.
    always_comb begin
        phase_chg    = (phase_d != phase_q);
        main_light_d = main_lamp(phase_d);
        side_light_d = side_lamp(phase_d);
    end

    assign phase      = phase_q;
    assign rst_count  = rst_count_q;
    assign main_light = main_light_q;
    assign side_light = side_light_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with short phase durations.
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sec_tick = 1'b0;
    logic       side_req = 1'b0;
    logic       emg_req = 1'b0;
    logic       rst_count;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [2:0] phase;
    logic       side_pending;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       emg;
        logic [2:0] ph;
        logic       rst;
    } vec_t;

    localparam int NVEC  = 26;
    localparam int SPLIT = 14;
    vec_t tbl [NVEC];

    traffic_phase_ctrl #(
        .T_MAIN_GREEN (4),
        .T_SIDE_GREEN (2),
        .T_YELLOW     (2),
        .T_ALL_RED    (1),
        .CNT_W        (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sec_tick     (sec_tick),
        .side_req     (side_req),
        .emg_req      (emg_req),
        .rst_count    (rst_count),
        .main_light   (main_light),
        .side_light   (side_light),
        .phase        (phase),
        .side_pending (side_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_main(input logic [2:0] p);
        case (p)
            3'd1:    exp_main = 3'b001;
            3'd2:    exp_main = 3'b010;
            default: exp_main = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input logic [2:0] p);
        case (p)
            3'd4:    exp_side = 3'b001;
            3'd5:    exp_side = 3'b010;
            default: exp_side = 3'b100;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] p, input logic r);
        chk({tag, "_phase"}, 8'(phase), 8'(p));
        chk({tag, "_rst"}, 8'(rst_count), 8'(r));
        chk({tag, "_main"}, 8'(main_light), 8'(exp_main(p)));
        chk({tag, "_side"}, 8'(side_light), 8'(exp_side(p)));
`ifndef SIDE_SENSOR_EN
        chk({tag, "_pend"}, 8'(side_pending), 8'd0);
`endif
    endtask

    // One 10-cycle tick period: tick is sampled on the second edge, state is
    // checked just after it, then again at the end of the period.
    task automatic step(input string tag, input logic e, input logic [2:0] p, input logic r);
        emg_req = e;
        @(posedge clk); #1 sec_tick = 1'b1;
        @(posedge clk); #1 sec_tick = 1'b0;
        chk_state(tag, p, r);
        repeat (8) @(posedge clk);
        #1;
        chk({tag, "_end_rst"}, 8'(rst_count), 8'd0);
        chk({tag, "_end_phase"}, 8'(phase), 8'(p));
    endtask

    initial begin
        // Fixed cycle 0,1,2,3,4,5,0 lasting 1,4,2,1,2,2 ticks, then MAIN_G again.
        tbl[0]  = '{1'b0, 3'd1, 1'b1};
        tbl[1]  = '{1'b0, 3'd1, 1'b0};
        tbl[2]  = '{1'b0, 3'd1, 1'b0};
        tbl[3]  = '{1'b0, 3'd1, 1'b0};
        tbl[4]  = '{1'b0, 3'd2, 1'b1};
        tbl[5]  = '{1'b0, 3'd2, 1'b0};
        tbl[6]  = '{1'b0, 3'd3, 1'b1};
        tbl[7]  = '{1'b0, 3'd4, 1'b1};
        tbl[8]  = '{1'b0, 3'd4, 1'b0};
        tbl[9]  = '{1'b0, 3'd5, 1'b1};
        tbl[10] = '{1'b0, 3'd5, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 1'b1};
        tbl[12] = '{1'b0, 3'd1, 1'b1};
        tbl[13] = '{1'b0, 3'd1, 1'b0};
        // After the emergency pulse: second yellow tick, then RED_S held by emg.
        tbl[14] = '{1'b0, 3'd2, 1'b0};
        tbl[15] = '{1'b0, 3'd3, 1'b1};
        for (int i = 16; i < 21; i++) tbl[i] = '{1'b1, 3'd3, 1'b0};
        tbl[21] = '{1'b0, 3'd4, 1'b1};
        tbl[22] = '{1'b0, 3'd4, 1'b0};
        tbl[23] = '{1'b0, 3'd5, 1'b1};
        tbl[24] = '{1'b0, 3'd5, 1'b0};
        tbl[25] = '{1'b0, 3'd0, 1'b1};

        side_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 3'd0, 1'b1);
        chk("reset_pend", 8'(side_pending), 8'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_state("rel", 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < SPLIT; i++) begin
            step($sformatf("v%0d", i), tbl[i].emg, tbl[i].ph, tbl[i].rst);
            if (i == 3) side_req = 1'b0;
        end

        // One-cycle emergency at MAIN_G tick 1, then a tick inside the
        // restart cycle that must not shorten the yellow.
        emg_req = 1'b1;
        @(posedge clk); #1 emg_req = 1'b0;
        chk_state("emg", 3'd2, 1'b1);
        sec_tick = 1'b1;
        @(posedge clk); #1 sec_tick = 1'b0;
        chk_state("coinc", 3'd2, 1'b0);
        repeat (5) @(posedge clk);
        #1;

        for (int i = SPLIT; i < NVEC; i++) begin
            step($sformatf("v%0d", i), tbl[i].emg, tbl[i].ph, tbl[i].rst);
        end

`ifdef SIDE_SENSOR_EN
        chk("pend_idle", 8'(side_pending), 8'd0);
        step("s_in", 1'b0, 3'd1, 1'b1);
        for (int i = 0; i < 9; i++) step($sformatf("s_hold%0d", i), 1'b0, 3'd1, 1'b0);
        @(posedge clk); #1 side_req = 1'b1;
        @(posedge clk); #1 side_req = 1'b0;
        chk("s_pend_set", 8'(side_pending), 8'd1);
        chk("s_pend_phase", 8'(phase), 8'd1);
        step("s_my", 1'b0, 3'd2, 1'b1);
        step("s_my2", 1'b0, 3'd2, 1'b0);
        step("s_rs", 1'b0, 3'd3, 1'b1);
        chk("s_pend_keep", 8'(side_pending), 8'd1);
        step("s_sg", 1'b0, 3'd4, 1'b1);
        chk("s_pend_clr", 8'(side_pending), 8'd0);
`else
        step("f_mg", 1'b0, 3'd1, 1'b1);
        for (int i = 0; i < 3; i++) step($sformatf("f_mg%0d", i), 1'b0, 3'd1, 1'b0);
        step("f_my", 1'b0, 3'd2, 1'b1);
        step("f_my2", 1'b0, 3'd2, 1'b0);
        step("f_rs", 1'b0, 3'd3, 1'b1);
        step("f_sg", 1'b0, 3'd4, 1'b1);
`endif
        step("t_sg2", 1'b0, 3'd4, 1'b0);
        step("t_sy", 1'b0, 3'd5, 1'b1);

        // Asynchronous reset in the middle of SIDE_Y.
        #3 reset = 1'b1;
        #1;
        chk_state("mid_rst", 3'd0, 1'b1);
        chk("mid_rst_pend", 8'(side_pending), 8'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        chk_state("mid_rel", 3'd0, 1'b0);
        step("post_rst", 1'b0, 3'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
